rs232_txb_cfg: RTL and testbench

Buffered, runtime-configurable RS232 transmitter: the next generation of the team's buffered serial transmitter. A FIFO of parametrised depth feeds a frame engine. Data bits (5–8), parity (none/even/odd), stop bits (1/2) and a 16-bit baud divisor are set per frame from ports instead of a fixed two-rate select. It sits on the IO bus behind the serial data/status registers. It adds transmit enable, FIFO flush, busy and a sticky overrun flag.

---
 rtl/rs232_txb_cfg.sv | 223 ++++++++++++++++++++++
 tb/tb_rs232_txb_cfg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_txb_cfg.sv
// Buffered RS232 transmitter: a byte FIFO feeds a frame engine with per-frame data/parity/stop/baud format.
// Latency: wr at edge k -> launch/pop at edge k+1 -> start bit on txd after k+1 (2 clocks write-to-start-bit).
// Backpressure: none on wr; a write while full is dropped and sets the sticky overrun flag.
//
// Ports: clk/rst_n (async active-low); wr/data_in push a byte; div/data_bits/parity/stop2 give the line
// format, latched at frame launch; tx_en gates new launches; flush empties the FIFO; clr_ovr clears
// overrun. Status: empty/full/count (FIFO), busy (engine active), overrun (sticky). txd is the line.
module rs232_txb_cfg #(
  parameter int BufNumSlots = 63,
  parameter int DivWidth    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr,
  input  logic [7:0]                    data_in,
  input  logic [DivWidth-1:0]           div,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity,
  input  logic                          stop2,
  input  logic                          tx_en,
  input  logic                          flush,
  input  logic                          clr_ovr,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(BufNumSlots):0]  count,
  output logic                          busy,
  output logic                          overrun,
  output logic                          txd
);

  localparam int PtrW = $clog2(BufNumSlots);
  localparam int CntW = PtrW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- FIFO ----------------
  logic [7:0]      mem_q [BufNumSlots];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            empty_q, empty_d, full_q, full_d;
  logic            overrun_q, overrun_d;
  logic            push, launch;
  logic [7:0]      head;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    push      = wr & ~full_q & ~flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push)
      wr_ptr_d = (wr_ptr_q == PtrW'(BufNumSlots - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (launch)
      rd_ptr_d = (rd_ptr_q == PtrW'(BufNumSlots - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    case ({push, launch})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    // Setting beats clearing when both happen in one cycle.
    if (wr & full_q)  overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
    empty_d = (count_d == '0);
    full_d  = (count_d == CntW'(BufNumSlots));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // ---------------- Frame engine ----------------
  state_t              state_q, state_d;
  logic [DivWidth-1:0] tmr_q, tmr_d, div_q, div_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic                stop_idx_q, stop_idx_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [1:0]          nbits_q, nbits_d;
  logic                par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic                stop2_q, stop2_d;
  logic                txd_q, txd_d;
  logic                can_launch, bit_end;
  logic [7:0]          dmask;
  logic [2:0]          last_idx;

  always_comb begin
    case (data_bits)
      2'b00:   dmask = 8'h1F;
      2'b01:   dmask = 8'h3F;
      2'b10:   dmask = 8'h7F;
      default: dmask = 8'hFF;
    endcase
  end

  assign can_launch = ~empty_q & tx_en & ~flush;
  assign bit_end    = (tmr_q == '0);
  assign last_idx   = 3'd4 + {1'b0, nbits_q};

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shreg_d    = shreg_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    txd_d      = txd_q;
    launch     = 1'b0;
    if (state_q != S_IDLE && !bit_end) tmr_d = tmr_q - DivWidth'(1);
    case (state_q)
      S_IDLE: if (can_launch) launch = 1'b1;
      S_START: if (bit_end) begin
        state_d   = S_DATA;
        tmr_d     = div_q;
        bit_idx_d = '0;
        txd_d     = shreg_q[0];
      end
      S_DATA: if (bit_end) begin
        tmr_d = div_q;
        if (bit_idx_q == last_idx) begin
          if (par_en_q) begin
            state_d = S_PAR;
            txd_d   = par_bit_q;
          end else begin
            state_d    = S_STOP;
            stop_idx_d = 1'b0;
            txd_d      = 1'b1;
          end
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          shreg_d   = shreg_q >> 1;
          txd_d     = shreg_q[1];
        end
      end
      S_PAR: if (bit_end) begin
        state_d    = S_STOP;
        tmr_d      = div_q;
        stop_idx_d = 1'b0;
        txd_d      = 1'b1;
      end
      S_STOP: if (bit_end) begin
        if (stop2_q && !stop_idx_q) begin
          stop_idx_d = 1'b1;
          tmr_d      = div_q;
        end else if (can_launch) begin
          launch = 1'b1;            // back-to-back: no idle gap
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Launch freezes the whole line format for the frame.
    if (launch) begin
      state_d   = S_START;
      tmr_d     = div;
      div_d     = div;
      shreg_d   = head;
      nbits_d   = data_bits;
      par_en_d  = (parity == 2'b01) || (parity == 2'b10);
      par_bit_d = (^(head & dmask)) ^ (parity == 2'b10);
      stop2_d   = stop2;
      txd_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      div_q      <= div_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shreg_q    <= shreg_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
    end
  end

  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign busy    = (state_q != S_IDLE);
  assign overrun = overrun_q;
  assign txd     = txd_q;

endmodule

// File: tb/tb_rs232_txb_cfg.sv
// Testbench for rs232_txb_cfg: random and directed frames checked against a line-level model.
// Inputs driven and outputs sampled on the falling clock edge.
// The model builds the expected txd waveform from frame rules and predicts FIFO occupancy.
module tb_rs232_txb_cfg;

  localparam int Slots = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr;
  logic [7:0]  data_in;
  logic [15:0] div;
  logic [1:0]  data_bits;
  logic [1:0]  parity;
  logic        stop2;
  logic        tx_en;
  logic        flush;
  logic        clr_ovr;
  logic        empty, full, busy, overrun, txd;
  logic [2:0]  count;

  always #5 clk = ~clk;

  rs232_txb_cfg #(.BufNumSlots(Slots), .DivWidth(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .div(div),
    .data_bits(data_bits), .parity(parity), .stop2(stop2), .tx_en(tx_en),
    .flush(flush), .clr_ovr(clr_ovr), .empty(empty), .full(full),
    .count(count), .busy(busy), .overrun(overrun), .txd(txd)
  );

  int         n_vec = 0;
  int         n_err = 0;
  bit         exp_q[$];
  int         flen_q[$];
  logic [7:0] bytes_a[5];

  task automatic chk(input string tag, input int obs, input int expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Append one frame's expected line waveform (each bit repeated dv+1 cycles).
  task automatic add_frame(input logic [7:0] b, input int db, input int par, input bit st2, input int dv);
    bit bits[$];
    int n, ones;
    n = 5 + db;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(b[i]);
      ones += int'(b[i]);
    end
    if (par == 1) bits.push_back(ones % 2 == 1);
    if (par == 2) bits.push_back(ones % 2 == 0);
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    foreach (bits[i]) repeat (dv + 1) exp_q.push_back(bits[i]);
    flen_q.push_back(bits.size() * (dv + 1));
  endtask

  // Write n bytes on consecutive cycles; nsent frames are expected on the line.
  // flush_j / txoff_j (>=0) pulse flush or drop tx_en at that cycle index.
  task automatic run_batch(input int n, input int nsent, input int db, input int par, input bit st2,
                           input int dv, input int flush_j, input int txoff_j);
    int  len, pops, s, exp_cnt;
    bit  plain, et;
    exp_q.delete();
    flen_q.delete();
    for (int f = 0; f < nsent; f++) add_frame(bytes_a[f], db, par, st2, dv);
    len   = exp_q.size();
    plain = (flush_j < 0) && (txoff_j < 0);
    @(negedge clk);
    div = 16'(dv); data_bits = 2'(db); parity = 2'(par); stop2 = st2; tx_en = 1'b1;
    for (int j = 0; j < len + 5; j++) begin
      @(negedge clk);
      et = (j >= 2 && j - 2 < len) ? exp_q[j - 2] : 1'b1;
      chk("txd", int'(txd), int'(et));
      chk("busy", int'(busy), int'(j >= 2 && j - 2 < len));
      if (plain) begin
        pops = 0;
        s = 0;
        foreach (flen_q[f]) begin
          if (1 + s <= j - 1) pops++;
          s += flen_q[f];
        end
        exp_cnt = ((j < n) ? j : n) - pops;
        chk("count", int'(count), exp_cnt);
        chk("empty", int'(empty), int'(exp_cnt == 0));
        chk("full", int'(full), int'(exp_cnt == Slots));
      end
      wr      = (j < n);
      data_in = (j < n) ? bytes_a[j] : 8'h00;
      flush   = (j == flush_j);
      if (txoff_j >= 0 && j >= txoff_j) tx_en = 1'b0;
      if (plain && n == 1 && j == 3) begin
        // Format changes mid-frame must not alter the frame in flight.
        div = 16'($urandom_range(0, 5)); data_bits = 2'($urandom);
        parity = 2'($urandom); stop2 = 1'($urandom);
      end
    end
    wr = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    int len;
    bit et;
    rst_n = 1'b0; wr = 1'b0; data_in = '0; div = '0; data_bits = 2'b11; parity = '0;
    stop2 = 1'b0; tx_en = 1'b1; flush = 1'b0; clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", int'(txd), 1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("idle_txd", int'(txd), 1);
      chk("idle_busy", int'(busy), 0);
      chk("idle_empty", int'(empty), 1);
      chk("idle_count", int'(count), 0);
    end

    // Directed: 8N1 0xA5 div=3; 7O2 0x03 div=0; three back-to-back 8N1 div=1.
    bytes_a[0] = 8'hA5;
    run_batch(1, 1, 3, 0, 1'b0, 3, -1, -1);
    bytes_a[0] = 8'h03;
    run_batch(1, 1, 2, 2, 1'b1, 0, -1, -1);
    bytes_a[0] = 8'h5A; bytes_a[1] = 8'hC3; bytes_a[2] = 8'h0F;
    run_batch(3, 3, 3, 0, 1'b0, 1, -1, -1);

    // Random format/data batches.
    repeat (25) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) bytes_a[i] = 8'($urandom);
      run_batch(n, n, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                $urandom_range(0, 3), -1, -1);
    end

    // Flush mid-frame with 3 bytes queued: only the first frame goes out.
    for (int i = 0; i < 4; i++) bytes_a[i] = 8'($urandom);
    run_batch(4, 1, 3, 0, 1'b0, 0, 5, -1);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);

    // tx_en dropped mid-frame: frame completes, second byte stays queued.
    run_batch(2, 1, 3, 1, 1'b0, 0, -1, 4);
    chk("txoff_count", int'(count), 1);
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    chk("txoff_flush_count", int'(count), 0);

    // Full / overrun with transmitter disabled.
    tx_en = 1'b0; div = 16'd0; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bytes_a[i] = 8'($urandom);
      wr = 1'b1;
      data_in = bytes_a[i];
      @(negedge clk);
    end
    wr = 1'b0;
    chk("ovr_count", int'(count), 4);
    chk("ovr_full", int'(full), 1);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_txd", int'(txd), 1);
    wr = 1'b1; clr_ovr = 1'b1;
    @(negedge clk);
    wr = 1'b0; clr_ovr = 1'b0;
    chk("ovr_set_wins", int'(overrun), 1);
    chk("ovr_count2", int'(count), 4);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("ovr_cleared", int'(overrun), 0);
    exp_q.delete();
    flen_q.delete();
    for (int f = 0; f < 4; f++) add_frame(bytes_a[f], 3, 0, 1'b0, 0);
    len = exp_q.size();
    tx_en = 1'b1;
    for (int j = 1; j < len + 4; j++) begin
      @(negedge clk);
      et = (j - 1 < len) ? exp_q[j - 1] : 1'b1;
      chk("ovr_txd_stream", int'(txd), int'(et));
    end
    chk("ovr_end_count", int'(count), 0);
    chk("ovr_end_empty", int'(empty), 1);

    // Asynchronous reset in the middle of a data bit.
    exp_q.delete();
    flen_q.delete();
    bytes_a[0] = 8'h00;
    add_frame(bytes_a[0], 3, 0, 1'b0, 3);
    div = 16'd3; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      et = (j >= 2) ? exp_q[j - 2] : 1'b1;
      chk("rstmid_txd", int'(txd), int'(et));
      wr = (j == 0);
      data_in = bytes_a[0];
    end
    chk("rstmid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_txd_async", int'(txd), 1);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_empty", int'(empty), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstmid_txd_after", int'(txd), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
